// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI frame width and master FSM state encoding
`timescale 1ns/1ps
package spi_pkg;
  localparam int SPI_FRAME_BITS = 8;
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, DONE} spi_mst_state_t;
endpackage

// File: rtl/spi_phase_timer.sv
// spi_phase_timer: free-running CLK_DIV phase counter, cleared by load, pulsing expire on its last cycle
`timescale 1ns/1ps
module spi_phase_timer #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic expire_o
);
  localparam int W = $clog2(CLK_DIV);
  logic [W-1:0] cnt_q;
  assign expire_o = cnt_q == W'(CLK_DIV - 1);
  // count phase cycles, restarting on load or after the last cycle of a phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= (load_i || expire_o) ? '0 : cnt_q + 1'b1;
  end
endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: mode-0 SPI master sending and receiving one word per frame with clk-derived sclk
`timescale 1ns/1ps
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tx_valid_i,
  output logic                      tx_ready_o,
  input  logic [SPI_FRAME_BITS-1:0] tx_data_i,
  output logic                      rx_valid_o,
  output logic [SPI_FRAME_BITS-1:0] rx_data_o,
  output logic                      busy_o,
  output logic                      sclk_o,
  output logic                      mosi_o,
  input  logic                      miso_i,
  output logic                      cs_n_o
);
  localparam int N = SPI_FRAME_BITS;

  if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_div
    $error("spi_master_ctrl: CLK_DIV must be in 2..255");
  end

  spi_mst_state_t state_q;
  logic [N-1:0]   tx_shift_q, rx_shift_q, rx_data_q;
  logic [2:0]     bit_cnt_q;
  logic           last_q, tx_ready_q, busy_q, rx_valid_q, sclk_q, mosi_q, cs_n_q;
  logic           expire;

  spi_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (state_q == IDLE),
    .expire_o(expire)
  );

  assign tx_ready_o = tx_ready_q;
  assign busy_o     = busy_q;
  assign rx_valid_o = rx_valid_q;
  assign rx_data_o  = rx_data_q;
  assign sclk_o     = sclk_q;
  assign mosi_o     = mosi_q;
  assign cs_n_o     = cs_n_q;

  // frame sequencer: miso is sampled on the same edge that raises sclk, so it still holds the slave's settled bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      last_q     <= 1'b0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (tx_valid_i) begin
          state_q    <= SETUP;
          tx_shift_q <= tx_data_i;
          mosi_q     <= tx_data_i[N-1];
          cs_n_q     <= 1'b0;
          tx_ready_q <= 1'b0;
          busy_q     <= 1'b1;
          bit_cnt_q  <= '0;
          last_q     <= 1'b0;
        end
        SETUP: if (expire) begin
          state_q    <= HIGH;
          sclk_q     <= 1'b1;
          rx_shift_q <= {rx_shift_q[N-2:0], miso_i};
        end
        HIGH: if (expire) begin
          state_q    <= LOW;
          sclk_q     <= 1'b0;
          tx_shift_q <= {tx_shift_q[N-2:0], 1'b0};
          mosi_q     <= tx_shift_q[N-2];
          bit_cnt_q  <= bit_cnt_q + 3'd1;
          last_q     <= &bit_cnt_q;
        end
        LOW: if (expire) begin
          if (last_q) begin
            state_q    <= DONE;
            cs_n_q     <= 1'b1;
            rx_valid_q <= 1'b1;
            rx_data_q  <= rx_shift_q;
            mosi_q     <= 1'b0;
          end else begin
            state_q    <= HIGH;
            sclk_q     <= 1'b1;
            rx_shift_q <= {rx_shift_q[N-2:0], miso_i};
          end
        end
        DONE: begin
          state_q    <= IDLE;
          tx_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

Mode-0 SPI master that sits directly upstream of the team's clk-domain SPI slave and drives its sclk/mosi, capturing miso. It accepts one 8-bit word per frame over a valid/ready handshake and generates chip select and a divided serial clock. It returns the simultaneously received word with a one-cycle valid pulse. Serial timing is derived from clk, so the downstream slave's edge detector sees clean, multi-cycle phases.

## Interface
- CLK_DIV, 2: sclk half-period in clk cycles; legal range 2..255; elaboration error if < 2.
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  master idle; transfer accepted when tx_valid && tx_ready.
- tx_data  in  8  word to send, MSB first.
- rx_valid  out  1  one-cycle pulse: rx_data holds the received word.
- rx_data  out  8  received word, MSB first; holds until the next rx_valid.
- busy  out  1  frame in progress (= !tx_ready).
- sclk  out  1  serial clock, idle low (CPOL=0).
- mosi  out  1  serial data out; changes only while sclk is low.
- miso  in  1  serial data in.
- cs_n  out  1  chip select, active low.

## Operation
- FSM states: IDLE, SETUP, HIGH, LOW, DONE.
- IDLE: tx_ready=1, cs_n=1, sclk=0. On handshake, latch tx_data into tx_shift, clear bit_cnt, and go to SETUP.
- SETUP: cs_n=0, mosi=tx_shift[7], sclk=0. Lasts CLK_DIV cycles, then HIGH.
- HIGH: sclk=1 for CLK_DIV cycles.
  - On the entry edge (the clk edge that registers sclk=1), rx_shift <= {rx_shift[6:0], miso}.
  - miso is sampled before the slave's response to that rising edge can arrive.
  - Exit to LOW.
- LOW: sclk=0 for CLK_DIV cycles.
  - On entry, tx_shift shifts left and mosi takes the next bit.
  - bit_cnt increments at the end of each HIGH phase.
  - After the 8th LOW phase go to DONE; otherwise go to HIGH.
- DONE (1 cycle): cs_n=1, rx_valid=1, rx_data=rx_shift, mosi=0. Next state IDLE.
- tx_valid while busy: ignored. No queuing; tx_data need not be held after the handshake.
- Reset values: tx_ready=1, busy=0, rx_valid=0, rx_data=0, sclk=0, mosi=0, cs_n=1, state=IDLE, counters=0.
- Reset mid-frame: all outputs return to their reset values asynchronously. No rx_valid is issued and the partial frame is discarded.
- Phase counter width: $clog2(CLK_DIV). It wraps to 0 on reaching CLK_DIV-1. bit_cnt is 3 bits plus a terminal flag.

## Timing
- Handshake at cycle 0 → cs_n low and mosi=bit7 from cycle 1.
- First sclk rise at cycle 1+CLK_DIV.
- cs_n low for exactly 17·CLK_DIV cycles (1 setup plus 16 half-periods).
- DONE, with rx_valid=1 and cs_n=1, at cycle 1+17·CLK_DIV. tx_ready=1 in the following cycle.
- CLK_DIV=2: cs_n low cycles 1..34; rx_valid in cycle 35; next handshake possible in cycle 36.
- mosi stability: mosi is stable ≥CLK_DIV cycles before and after every sclk rise. This satisfies the slave's 1-cycle-delay edge detector.
- All outputs are registered. No combinational path exists from inputs to outputs.

## Structure
- Shared package spi_pkg:
  - state enum spi_mst_state_t {IDLE, SETUP, HIGH, LOW, DONE};
  - localparam SPI_FRAME_BITS = 8, shared with the slave.
- Sub-module spi_phase_timer: CLK_DIV counter with load/expire outputs. It is reusable by future slave-side timeout logic.
- The top level holds the FSM, both shift registers, and the output registers.

## Test plan
- Loopback with the slave, CLK_DIV=2, slave data_in=0x3C at reset, send 0xA5 → master rx_data=0x3C with rx_valid in cycle 35; slave data_out=0xA5 and done=1.
- Second frame with no slave reset, send 0x0F → slave data_out=0x0F; master rx_data=0x00, because the slave output register has drained.
- miso tied to mosi, CLK_DIV=4, send 0x81 → rx_data=0x81. Check cs_n low for 68 cycles and each sclk high/low phase lasting 4 cycles.
- tx_valid held high continuously with changing data (0x11, 0x22) → exactly one frame per idle window. tx_ready low throughout each frame, then high for one cycle before the next accept.
- rst_n asserted at mid-frame bit 4 → same cycle: cs_n=1, sclk=0, mosi=0, tx_ready=1. No rx_valid; a subsequent 0x5A frame completes normally.
- Data changes check: assert mosi never toggles while sclk=1, and sclk is 0 whenever cs_n=1.
